// File: rtl/spi_pkg.sv
// Shared definitions for the SPI chip-select controller: FSM encoding and
// default CS timing.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_LAUNCH,
    ST_XFER,
    ST_NEXT,
    ST_HOLD,
    ST_DESEL
  } cs_state_t;

  localparam int DEF_MAX_BYTES_PER_CS = 2;
  localparam int DEF_CS_SETUP_CLKS    = 2;
  localparam int DEF_CS_HOLD_CLKS     = 2;
  localparam int DEF_CS_IDLE_CLKS     = 4;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/spi_cs_controller_if.sv
// Host-side byte port of the CS controller: the host (master) pushes TX bytes
// and the controller (slave) returns RX bytes with their index.
interface spi_cs_controller_if #(
  parameter int CW = 2
);
  logic [CW-1:0] TX_Count;
  logic [7:0]    TX_Byte;
  logic          TX_DV;
  logic          TX_Ready;
  logic          RX_DV;
  logic [7:0]    RX_Byte;
  logic [CW-1:0] RX_Count;

  modport master (
    output TX_Count, TX_Byte, TX_DV,
    input  TX_Ready, RX_DV, RX_Byte, RX_Count
  );

  modport slave (
    input  TX_Count, TX_Byte, TX_DV,
    output TX_Ready, RX_DV, RX_Byte, RX_Count
  );
endinterface

// File: rtl/spi_cs_timer.sv
// Load/count-down timer shared by the SETUP, HOLD and DESEL phases.
// Load (N-1) on entry; done while the count sits at zero, which takes N cycles.
module spi_cs_timer #(
  parameter int TW = 3
) (
  input  logic          i_Clk,
  input  logic          i_Rst,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  output logic          done
);

  logic [TW-1:0] cnt;

  // Saturates at zero rather than wrapping.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst)             cnt <= '0;
    else if (load)         cnt <= load_val;
    else if (cnt != '0)    cnt <= cnt - TW'(1);
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/spi_cs_controller.sv
// Chip-select controller in front of a byte-serial SPI engine: groups up to
// MAX_BYTES_PER_CS bytes per CS-low window and enforces setup/hold/deselect.
module spi_cs_controller
  import spi_pkg::*;
#(
  parameter int MAX_BYTES_PER_CS = DEF_MAX_BYTES_PER_CS,
  parameter int CS_SETUP_CLKS    = DEF_CS_SETUP_CLKS,
  parameter int CS_HOLD_CLKS     = DEF_CS_HOLD_CLKS,
  parameter int CS_IDLE_CLKS     = DEF_CS_IDLE_CLKS
) (
  input  logic                i_Clk,
  input  logic                i_Rst,
  spi_cs_controller_if.slave  host,
  output logic                o_SPI_CS_n,
  output logic [7:0]          o_M_TX_Byte,
  output logic                o_M_TX_DV,
  input  logic                i_M_TX_Ready,
  input  logic                i_M_RX_DV,
  input  logic [7:0]          i_M_RX_Byte
);

  localparam int CW = $clog2(MAX_BYTES_PER_CS + 1);
  localparam int TW = $clog2(max3(CS_SETUP_CLKS, CS_HOLD_CLKS, CS_IDLE_CLKS) + 1);

  cs_state_t     state;
  logic [CW-1:0] rem, idx, req_cnt;
  logic          tx_ready, rx_dv;
  logic [7:0]    rx_byte;
  logic [CW-1:0] rx_count;
  logic          accept_idle, accept_next, rx_last;
  logic          tmr_load, tmr_done;
  logic [TW-1:0] tmr_val;

  assign host.TX_Ready = tx_ready;
  assign host.RX_DV    = rx_dv;
  assign host.RX_Byte  = rx_byte;
  assign host.RX_Count = rx_count;

  assign req_cnt = (host.TX_Count > CW'(MAX_BYTES_PER_CS)) ? CW'(MAX_BYTES_PER_CS)
                                                          : host.TX_Count;
  assign accept_idle = (state == ST_IDLE) && tx_ready && host.TX_DV && (host.TX_Count != '0);
  assign accept_next = (state == ST_NEXT) && tx_ready && host.TX_DV;
  assign rx_last     = (rem == CW'(1));

  // Timer reloads on the edge that enters each timed phase.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    if (accept_idle) begin
      tmr_load = 1'b1;
      tmr_val  = TW'(CS_SETUP_CLKS - 1);
    end else if (state == ST_XFER && i_M_RX_DV && rx_last) begin
      tmr_load = 1'b1;
      tmr_val  = TW'(CS_HOLD_CLKS - 1);
    end else if (state == ST_HOLD && tmr_done) begin
      tmr_load = 1'b1;
      tmr_val  = TW'(CS_IDLE_CLKS - 1);
    end
  end

  spi_cs_timer #(.TW(TW)) u_timer (
    .i_Clk    (i_Clk),
    .i_Rst    (i_Rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state       <= ST_IDLE;
      o_SPI_CS_n  <= 1'b1;
      tx_ready    <= 1'b0;
      rx_dv       <= 1'b0;
      rx_byte     <= '0;
      rx_count    <= '0;
      o_M_TX_Byte <= '0;
      o_M_TX_DV   <= 1'b0;
      rem         <= '0;
      idx         <= '0;
    end else begin
      rx_dv     <= 1'b0;
      o_M_TX_DV <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          tx_ready <= 1'b1;
          if (accept_idle) begin
            o_M_TX_Byte <= host.TX_Byte;
            rem         <= req_cnt;
            idx         <= '0;
            rx_count    <= '0;
            tx_ready    <= 1'b0;
            o_SPI_CS_n  <= 1'b0;
            state       <= ST_SETUP;
          end
        end
        ST_SETUP: if (tmr_done) state <= ST_LAUNCH;
        ST_LAUNCH: begin
          if (i_M_TX_Ready) begin
            o_M_TX_DV <= 1'b1;
            state     <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (i_M_RX_DV) begin
            rx_dv    <= 1'b1;
            rx_byte  <= i_M_RX_Byte;
            rx_count <= idx;
            idx      <= idx + CW'(1);
            rem      <= rem - CW'(1);
            if (rx_last) begin
              state <= ST_HOLD;
            end else begin
              tx_ready <= 1'b1;
              state    <= ST_NEXT;
            end
          end
        end
        // CS stays low here for as long as the host takes to supply the next byte.
        ST_NEXT: begin
          if (accept_next) begin
            o_M_TX_Byte <= host.TX_Byte;
            tx_ready    <= 1'b0;
            state       <= ST_LAUNCH;
          end
        end
        ST_HOLD: begin
          if (tmr_done) begin
            o_SPI_CS_n <= 1'b1;
            state      <= ST_DESEL;
          end
        end
        ST_DESEL: begin
          if (tmr_done) begin
            tx_ready <= 1'b1;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_cs_controller.sv
// Directed bench: CS controller plus a behavioural byte engine with MISO looped
// back to MOSI, so every received byte equals the byte sent.
module tb_spi_cs_controller;

  localparam int MAXB     = 2;
  localparam int SETUP    = 2;
  localparam int HOLD     = 2;
  localparam int IDLE     = 4;
  localparam int CW       = $clog2(MAXB + 1);
  localparam int ENG_CLKS = 8 * 2 * 2;  // 8 bits x 2 half-bits x CLKS_PER_HALF_BIT=2

  logic       i_Clk = 1'b0;
  logic       i_Rst = 1'b1;
  logic       cs_n;
  logic [7:0] m_tx_byte;
  logic       m_tx_dv;
  logic       m_tx_ready;
  logic       m_rx_dv   = 1'b0;
  logic [7:0] m_rx_byte = '0;
  int         eng_cnt   = 0;
  logic [7:0] eng_sh    = '0;

  spi_cs_controller_if #(.CW(CW)) hif ();

  spi_cs_controller #(
    .MAX_BYTES_PER_CS (MAXB),
    .CS_SETUP_CLKS    (SETUP),
    .CS_HOLD_CLKS     (HOLD),
    .CS_IDLE_CLKS     (IDLE)
  ) dut (
    .i_Clk        (i_Clk),
    .i_Rst        (i_Rst),
    .host         (hif),
    .o_SPI_CS_n   (cs_n),
    .o_M_TX_Byte  (m_tx_byte),
    .o_M_TX_DV    (m_tx_dv),
    .i_M_TX_Ready (m_tx_ready),
    .i_M_RX_DV    (m_rx_dv),
    .i_M_RX_Byte  (m_rx_byte)
  );

  always #5 i_Clk = ~i_Clk;

  // Byte engine model; deliberately not reset with the controller.
  assign m_tx_ready = (eng_cnt == 0);
  always @(posedge i_Clk) begin
    m_rx_dv <= 1'b0;
    if (eng_cnt == 0) begin
      if (m_tx_dv) begin
        eng_cnt <= ENG_CLKS;
        eng_sh  <= m_tx_byte;
      end
    end else begin
      eng_cnt <= eng_cnt - 1;
      if (eng_cnt == 1) begin
        m_rx_dv   <= 1'b1;
        m_rx_byte <= eng_sh;
      end
    end
  end

  // Per-cycle monitor: CS edges, engine pulses, protocol violations, RX log.
  int         cyc = 0, hi_run = 0, min_hi = 1000, fall_cyc = 0;
  int         last_setup = 0, min_setup = 1000;
  int         n_fall = 0, n_rise = 0, n_pulse = 0, viol = 0;
  logic       cs_q = 1'b1, seen_rise = 1'b0, want_dv = 1'b0;
  logic [7:0] rx_b[$];
  logic [CW-1:0] rx_i[$];

  always @(negedge i_Clk) begin
    cyc  <= cyc + 1;
    cs_q <= cs_n;
    if (cs_n) hi_run <= hi_run + 1;
    if (cs_q && !cs_n) begin
      n_fall   <= n_fall + 1;
      fall_cyc <= cyc;
      want_dv  <= 1'b1;
      if (seen_rise && hi_run < min_hi) min_hi <= hi_run;
      hi_run   <= 0;
    end
    if (!cs_q && cs_n) begin
      n_rise    <= n_rise + 1;
      seen_rise <= 1'b1;
    end
    if (m_tx_dv) begin
      n_pulse <= n_pulse + 1;
      if (!m_tx_ready || cs_n) viol <= viol + 1;
      if (want_dv) begin
        want_dv    <= 1'b0;
        last_setup <= cyc - fall_cyc;
        if (cyc - fall_cyc < min_setup) min_setup <= cyc - fall_cyc;
      end
    end
    if (hif.RX_DV) begin
      if (cs_n) viol <= viol + 1;
      rx_b.push_back(hif.RX_Byte);
      rx_i.push_back(hif.RX_Count);
    end
  end

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_first(input logic [CW-1:0] c, input logic [7:0] b);
    int n = 0;
    while (!hif.TX_Ready && n < 300) begin @(negedge i_Clk); n++; end
    chk("rdy_first", 32'(hif.TX_Ready), 1);
    hif.TX_Count = c; hif.TX_Byte = b; hif.TX_DV = 1'b1;
    @(negedge i_Clk);
    hif.TX_DV = 1'b0;
  endtask

  task automatic send_next(input logic [7:0] b);
    int n = 0;
    while (!hif.TX_Ready && n < 300) begin @(negedge i_Clk); n++; end
    chk("rdy_next", 32'(hif.TX_Ready), 1);
    hif.TX_Byte = b; hif.TX_DV = 1'b1;
    @(negedge i_Clk);
    hif.TX_DV = 1'b0;
  endtask

  task automatic wait_rx();
    int n = 0;
    while (!hif.RX_DV && n < 200) begin @(negedge i_Clk); n++; end
    chk("rx_seen", 32'(hif.RX_DV), 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(hif.TX_Ready && cs_n) && n < 300) begin @(negedge i_Clk); n++; end
    chk("idle", 32'(hif.TX_Ready && cs_n), 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, p0, f0, r0, n, bad;
    hif.TX_DV = 1'b0; hif.TX_Count = '0; hif.TX_Byte = '0;
    repeat (3) @(negedge i_Clk);

    // Reset state
    chk("rst_cs_n",     32'(cs_n), 1);
    chk("rst_tx_ready", 32'(hif.TX_Ready), 0);
    chk("rst_rx_dv",    32'(hif.RX_DV), 0);
    chk("rst_rx_byte",  32'(hif.RX_Byte), 0);
    chk("rst_rx_count", 32'(hif.RX_Count), 0);
    chk("rst_m_tx_dv",  32'(m_tx_dv), 0);
    chk("rst_m_tx_byte",32'(m_tx_byte), 0);
    i_Rst = 1'b0;
    @(negedge i_Clk);
    chk("idle_ready", 32'(hif.TX_Ready), 1);

    // 1: single byte with exact CS timing
    base = rx_b.size(); p0 = n_pulse;
    send_first(CW'(1), 8'hA5);
    chk("t1_cs_low",   32'(cs_n), 0);
    chk("t1_rdy_low",  32'(hif.TX_Ready), 0);
    wait_rx();
    chk("t1_rx_byte",  32'(hif.RX_Byte), 32'h A5);
    chk("t1_rx_idx",   32'(hif.RX_Count), 0);
    chk("t1_cs_h1",    32'(cs_n), 0);
    @(negedge i_Clk);
    chk("t1_cs_h2",    32'(cs_n), 0);
    @(negedge i_Clk);
    chk("t1_cs_up",    32'(cs_n), 1);
    n = 0;
    while (!hif.TX_Ready && n < 20) begin @(negedge i_Clk); n++; end
    chk("t1_desel",    32'(n), IDLE);
    chk("t1_pulses",   32'(n_pulse - p0), 1);
    chk("t1_setup",    32'(last_setup >= SETUP), 1);
    chk("t1_nrx",      32'(rx_b.size() - base), 1);

    // 2: two bytes in one CS window
    base = rx_b.size(); p0 = n_pulse; f0 = n_fall; r0 = n_rise;
    send_first(CW'(2), 8'h3C);
    send_next(8'hC3);
    wait_idle();
    chk("t2_nrx",   32'(rx_b.size() - base), 2);
    chk("t2_b0",    32'(rx_b[base]), 32'h3C);
    chk("t2_b1",    32'(rx_b[base+1]), 32'hC3);
    chk("t2_i0",    32'(rx_i[base]), 0);
    chk("t2_i1",    32'(rx_i[base+1]), 1);
    chk("t2_pulses",32'(n_pulse - p0), 2);
    chk("t2_falls", 32'(n_fall - f0), 1);
    chk("t2_rises", 32'(n_rise - r0), 1);

    // 3: host stalls 50 cycles between bytes
    base = rx_b.size(); p0 = n_pulse; r0 = n_rise;
    send_first(CW'(2), 8'h11);
    wait_rx();
    bad = 0;
    repeat (50) begin
      if (cs_n || !hif.TX_Ready) bad++;
      @(negedge i_Clk);
    end
    chk("t3_stall",      32'(bad), 0);
    chk("t3_pulses_mid", 32'(n_pulse - p0), 1);
    send_next(8'h22);
    wait_idle();
    chk("t3_b1",     32'(rx_b[base+1]), 32'h22);
    chk("t3_i1",     32'(rx_i[base+1]), 1);
    chk("t3_pulses", 32'(n_pulse - p0), 2);
    chk("t3_rises",  32'(n_rise - r0), 1);

    // 4a: zero count is ignored
    f0 = n_fall;
    hif.TX_Count = '0; hif.TX_Byte = 8'hFF; hif.TX_DV = 1'b1;
    @(negedge i_Clk);
    hif.TX_DV = 1'b0;
    repeat (10) @(negedge i_Clk);
    chk("t4_zero_fall",  32'(n_fall - f0), 0);
    chk("t4_zero_ready", 32'(hif.TX_Ready), 1);

    // 4b: TX_DV during XFER is dropped
    base = rx_b.size(); p0 = n_pulse;
    send_first(CW'(1), 8'h77);
    repeat (8) @(negedge i_Clk);
    hif.TX_Byte = 8'hEE; hif.TX_DV = 1'b1;
    repeat (3) @(negedge i_Clk);
    hif.TX_DV = 1'b0;
    wait_idle();
    chk("t4_drop_nrx",  32'(rx_b.size() - base), 1);
    chk("t4_drop_b0",   32'(rx_b[base]), 32'h77);
    chk("t4_drop_pls",  32'(n_pulse - p0), 1);
    chk("t4_drop_mtx",  32'(m_tx_byte), 32'h77);

    // 4c: over-range count (largest encodable) clamps to MAXB bytes
    base = rx_b.size(); p0 = n_pulse;
    send_first(CW'(3), 8'h81);
    send_next(8'h42);
    wait_idle();
    chk("t4_clamp_nrx", 32'(rx_b.size() - base), 2);
    chk("t4_clamp_b1",  32'(rx_b[base+1]), 32'h42);
    chk("t4_clamp_pls", 32'(n_pulse - p0), 2);

    // 5: async reset mid-XFER
    base = rx_b.size();
    send_first(CW'(1), 8'h99);
    repeat (10) @(negedge i_Clk);
    chk("t5_cs_pre", 32'(cs_n), 0);
    #2 i_Rst = 1'b1;
    #1;
    chk("t5_cs_async",  32'(cs_n), 1);
    chk("t5_rdy_async", 32'(hif.TX_Ready), 0);
    repeat (2) @(negedge i_Clk);
    i_Rst = 1'b0;
    repeat (40) @(negedge i_Clk);
    chk("t5_no_rx", 32'(rx_b.size() - base), 0);
    send_first(CW'(1), 8'h5A);
    wait_idle();
    chk("t5_nrx", 32'(rx_b.size() - base), 1);
    chk("t5_b0",  32'(rx_b[base]), 32'h5A);
    chk("t5_i0",  32'(rx_i[base]), 0);

    // 6: back-to-back single-byte transactions
    base = rx_b.size();
    send_first(CW'(1), 8'h10);
    send_first(CW'(1), 8'h20);
    send_first(CW'(1), 8'h30);
    wait_idle();
    chk("t6_nrx", 32'(rx_b.size() - base), 3);
    chk("t6_b0",  32'(rx_b[base]), 32'h10);
    chk("t6_b1",  32'(rx_b[base+1]), 32'h20);
    chk("t6_b2",  32'(rx_b[base+2]), 32'h30);

    // Whole-run timing and protocol monitors
    chk("min_desel_gap", 32'(min_hi >= IDLE), 1);
    chk("min_setup_gap", 32'(min_setup >= SETUP), 1);
    chk("protocol_viol", 32'(viol), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
